// File: rtl/ws2812_rx.sv
// WS2812 line receiver: decodes GRB bit stream into RGB888 words per LED.
// Optional pulse-width checking is compiled in with WS2812_RX_ERRCHK_EN.
module ws2812_rx #(
  parameter int unsigned DEPTH  = 24,
  parameter logic [31:0] CLKHZ  = 32'd50_000_000,
  parameter int unsigned WS_NUM = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  output logic             pix_valid,
  output logic [31:0]      pix_index,
  output logic [DEPTH-1:0] pix_rgb,
  output logic             frame_done,
  output logic [31:0]      frame_words,
  output logic             err
);

  localparam logic [31:0] NS       = 32'd1_000_000_000 / CLKHZ;
  localparam logic [31:0] TIME_BIT = 32'd525 / NS;
  localparam logic [31:0] TIME_RES = 32'd50_000 / NS;
`ifdef WS2812_RX_ERRCHK_EN
  localparam logic [31:0] TIME_HMIN = 32'd100 / NS;
  localparam logic [31:0] TIME_HMAX = 32'd1500 / NS;
`endif
  localparam int unsigned BW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] DEPTH_C = BW'(DEPTH);
  localparam logic [31:0] WS_NUM_C = 32'(WS_NUM);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LOW,
    ST_HIGH
  } state_t;

  state_t state, state_d;

  logic s1, s2, s3;
  logic din_s, rise, fall, edge_s;
  logic [31:0] cnt_pulse;
  logic [BW-1:0] bit_cnt;
  logic [DEPTH-1:0] shreg;
  logic [31:0] word_cnt;
  logic do_bit, do_gap, bad, bit_val;

  assign din_s  = s2;
  assign rise   = din_s & ~s3;
  assign fall   = ~din_s & s3;
  assign edge_s = rise | fall;
  assign bit_val = (cnt_pulse >= TIME_BIT - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= data_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_pulse <= '0;
    end else if (edge_s) begin
      cnt_pulse <= '0;
    end else if (cnt_pulse < TIME_RES) begin
      cnt_pulse <= cnt_pulse + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    do_bit  = 1'b0;
    do_gap  = 1'b0;
    bad     = 1'b0;
    unique case (state)
      ST_SYNC: begin
        if (!din_s && !edge_s && cnt_pulse >= TIME_RES - 32'd1)
          state_d = ST_LOW;
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (cnt_pulse == TIME_RES - 32'd1 &&
                     (word_cnt != '0 || bit_cnt != '0)) begin
          do_gap = 1'b1;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
`ifdef WS2812_RX_ERRCHK_EN
          if (cnt_pulse < TIME_HMIN - 32'd1 ||
              cnt_pulse > TIME_HMAX - 32'd1)
            bad = 1'b1;
          else
            do_bit = 1'b1;
`else
          do_bit = 1'b1;
`endif
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Completed word is emitted the cycle after its last bit is shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_index   <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_words <= '0;
      err         <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      word_cnt    <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (do_gap) begin
        frame_done  <= 1'b1;
        frame_words <= word_cnt;
        word_cnt    <= '0;
        bit_cnt     <= '0;
        shreg       <= '0;
      end else if (bit_cnt == DEPTH_C) begin
        pix_rgb   <= {shreg[15:8], shreg[23:16], shreg[7:0]};
        pix_index <= word_cnt;
        pix_valid <= (word_cnt < WS_NUM_C);
        if (word_cnt != '1) word_cnt <= word_cnt + 32'd1;
        bit_cnt <= '0;
      end else if (do_bit) begin
        shreg   <= {shreg[DEPTH-2:0], bit_val};
        bit_cnt <= bit_cnt + BW'(1);
      end else if (bad) begin
        err     <= 1'b1;
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx at 50 MHz.
// Exercises frame decode, word drop, partial gaps, sync wait, glitch, reset.
module tb_ws2812_rx;

  logic        clk;
  logic        rst_n;
  logic        data_in;
  logic        pix_valid;
  logic [31:0] pix_index;
  logic [23:0] pix_rgb;
  logic        frame_done;
  logic [31:0] frame_words;
  logic        err;

  ws2812_rx dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .pix_valid(pix_valid),
    .pix_index(pix_index),
    .pix_rgb(pix_rgb),
    .frame_done(frame_done),
    .frame_words(frame_words),
    .err(err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] idx;
    logic [23:0] rgb;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [23:0] rgb;
    logic [31:0] exp_idx;
    bit          exp_valid;
  } vec_t;

  ev_t         ev_q[$];
  logic [31:0] fd_q[$];
  int          fall_q[$];
  int          err_n;
  int          cyc;
  int          total;
  int          passed;
  vec_t        tv[9];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid) ev_q.push_back('{pix_index, pix_rgb, cyc});
    if (frame_done) fd_q.push_back(frame_words);
    if (err) err_n = err_n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clr();
    ev_q.delete();
    fd_q.delete();
    fall_q.delete();
    err_n = 0;
  endtask

  task automatic send_bit(input bit b);
    data_in = 1'b1;
    repeat (b ? 35 : 18) @(negedge clk);
    data_in = 1'b0;
    fall_q.push_back(cyc);
    repeat (b ? 28 : 45) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] rgb);
    logic [23:0] grb;
    grb = {rgb[15:8], rgb[23:16], rgb[7:0]};
    for (int i = 23; i >= 0; i--) send_bit(grb[i]);
  endtask

  task automatic gap(input int n);
    data_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_one_frame(input string name, input logic [31:0] words);
    chk({name, "_fd_n"}, fd_q.size(), 1);
    if (fd_q.size() > 0) chk({name, "_fwords"}, fd_q[0], words);
  endtask

  initial begin
    logic [23:0] colors[9];
    int n;
    total = 0;
    passed = 0;
    err_n = 0;
    cyc = 0;
    colors = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456,
               24'hA5A5A5, 24'h000000, 24'hFFFFFF, 24'h0F1E2D,
               24'h808080};
    for (int i = 0; i < 9; i++) tv[i] = '{colors[i], 32'(i), i < 7};

    rst_n = 1'b0;
    data_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", {31'd0, pix_valid}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_rgb", {8'd0, pix_rgb}, 0);
    chk("rst_idx", pix_index, 0);
    chk("rst_fwords", frame_words, 0);
    rst_n = 1'b1;
    gap(3000);

    // 1: seven-LED frame
    clr();
    for (int i = 0; i < 7; i++) send_word(tv[i].rgb);
    gap(3000);
    chk("t1_count", ev_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < ev_q.size()) begin
        chk("t1_idx", ev_q[i].idx, tv[i].exp_idx);
        chk("t1_rgb", {8'd0, ev_q[i].rgb}, {8'd0, tv[i].rgb});
      end
    end
    if (ev_q.size() > 0 && fall_q.size() >= 24)
      chk("t1_latency", ev_q[0].cyc - fall_q[23], 4);
    chk_one_frame("t1", 7);

    // 2: nine words, last two dropped
    clr();
    for (int i = 0; i < 9; i++) send_word(tv[i].rgb);
    gap(3000);
    n = 0;
    for (int i = 0; i < 9; i++) begin
      if (tv[i].exp_valid && n < ev_q.size()) begin
        chk("t2_idx", ev_q[n].idx, tv[i].exp_idx);
        chk("t2_rgb", {8'd0, ev_q[n].rgb}, {8'd0, tv[i].rgb});
      end
      if (tv[i].exp_valid) n++;
    end
    chk("t2_count", ev_q.size(), n);
    chk_one_frame("t2", 9);

    // 3: partial word then gap
    clr();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    gap(3000);
    chk("t3_count", ev_q.size(), 0);
    chk_one_frame("t3", 0);
    clr();
    send_word(24'h123456);
    gap(3000);
    chk("t3b_count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      chk("t3b_idx", ev_q[0].idx, 0);
      chk("t3b_rgb", {8'd0, ev_q[0].rgb}, 32'h123456);
    end
    chk_one_frame("t3b", 1);

    // 5: 60 ns glitch mid-word
    clr();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    data_in = 1'b0;
    repeat (45) @(negedge clk);
`ifdef WS2812_RX_ERRCHK_EN
    send_word(24'h3C5AA5);
    gap(3000);
    chk("t5_err", err_n, 1);
    chk("t5_count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      chk("t5_idx", ev_q[0].idx, 0);
      chk("t5_rgb", {8'd0, ev_q[0].rgb}, 32'h3C5AA5);
    end
    chk_one_frame("t5", 1);
`else
    gap(3000);
    chk("t5_err", err_n, 0);
    chk("t5_count", ev_q.size(), 0);
    chk_one_frame("t5", 0);
`endif

    // 4: reset with short idle, decode only after a full gap
    clr();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gap(1000);
    send_word(24'hDEAD01);
    chk("t4_nodec", ev_q.size(), 0);
    gap(3000);
    chk("t4_nogap", fd_q.size(), 0);
    send_word(24'h0A0B0C);
    gap(3000);
    chk("t4_count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      chk("t4_idx", ev_q[0].idx, 0);
      chk("t4_rgb", {8'd0, ev_q[0].rgb}, 32'h0A0B0C);
    end
    chk_one_frame("t4", 1);

    // 6: asynchronous reset mid-word
    clr();
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rgb", {8'd0, pix_rgb}, 0);
    chk("t6_fwords", frame_words, 0);
    chk("t6_state", 32'(dut.state), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gap(3000);
    send_word(24'h55AA11);
    gap(3000);
    chk("t6_count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      chk("t6_idx", ev_q[0].idx, 0);
      chk("t6_rgb2", {8'd0, ev_q[0].rgb}, 32'h55AA11);
    end
    chk_one_frame("t6", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
